// File: rtl/cory_arb16.sv
// cory_arb16: round-robin select-token scheduler for a 16-input valid/ready mux.
// Issues 4-bit select tokens on a valid/ready handshake, with bounded bursts per
// requester. Optional feature macro: CORY_ARB16_PRIO_EN adds a priority mask
// input i_prio that biases the winner search toward flagged requesters.
module cory_arb16 #(
    parameter int BURST = 4,
    parameter int PARK  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_en,
    input  logic [15:0] i_req,
`ifdef CORY_ARB16_PRIO_EN
    input  logic [15:0] i_prio,
`endif
    output logic        o_s_v,
    output logic [3:0]  o_s_d,
    input  logic        i_s_r,
    output logic        o_busy,
    output logic [7:0]  o_cnt
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t      state_q, state_n;
    logic [3:0]  ptr_q, ptr_n;
    logic [3:0]  cur_q, cur_n;
    logic [3:0]  sd_q, sd_n;
    logic [7:0]  cnt_q, cnt_n;
    logic [15:0] search_vec;
    logic        burst_prio_ok;
    logic        cnt_more;
    logic [4:0]  win_idle;
    logic [4:0]  win_rot;

    // First set bit of req scanning upward from p with wrap; returns {hit, index}.
    function automatic logic [4:0] find_win(input logic [15:0] req, input logic [3:0] p);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int i = 0; i < 16; i++) begin
            idx = p + 4'(i);
            if (!res[4] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef CORY_ARB16_PRIO_EN
    logic [15:0] prio_hit;
    // Priority requesters win the search when any are active; a normal burst
    // yields as soon as some other priority requester is waiting.
    always_comb begin
        prio_hit      = i_req & i_prio;
        search_vec    = (|prio_hit) ? prio_hit : i_req;
        burst_prio_ok = i_prio[cur_q] || ~|(prio_hit & ~(16'd1 << cur_q));
    end
`else
    // Pure round robin: search the raw request vector, bursts never yield early.
    always_comb begin
        search_vec    = i_req;
        burst_prio_ok = 1'b1;
    end
`endif

    assign win_idle = find_win(search_vec, ptr_q);
    assign win_rot  = find_win(search_vec, cur_q + 4'd1);
    assign cnt_more = (int'(cnt_q) + 1) < BURST;

    // Next-state logic: start offers from IDLE, continue or rotate on accept.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        cur_n   = cur_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_en && win_idle[4]) begin
                    state_n = OFFER;
                    cur_n   = win_idle[3:0];
                    cnt_n   = 8'd0;
                end
            end
            OFFER: begin
                if (i_s_r) begin
                    if (cnt_more && i_req[cur_q] && i_en && burst_prio_ok) begin
                        cnt_n = cnt_q + 8'd1;
                    end else begin
                        // Rotation searches from the slot after the winner so the
                        // next offer follows with no idle bubble.
                        ptr_n = cur_q + 4'd1;
                        cnt_n = 8'd0;
                        if (i_en && win_rot[4]) begin
                            cur_n = win_rot[3:0];
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        sd_n = (state_n == OFFER || PARK != 0) ? cur_n : 4'd0;
    end

    // State and output registers; reset discards any outstanding token.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            cur_q   <= 4'd0;
            sd_q    <= 4'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            cur_q   <= cur_n;
            sd_q    <= sd_n;
            cnt_q   <= cnt_n;
        end
    end

    assign o_s_v  = (state_q == OFFER);
    assign o_busy = (state_q == OFFER);
    assign o_s_d  = sd_q;
    assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_cory_arb16.sv
// tb_cory_arb16: directed checks of cory_arb16 in several parameterisations
// sharing one set of stimulus inputs.
module tb_cory_arb16;

    logic        clk;
    logic        reset_n;
    logic        i_en;
    logic [15:0] i_req;
    logic        i_s_r;
`ifdef CORY_ARB16_PRIO_EN
    logic [15:0] i_prio;
`endif

    logic       v1, busy1, v4, busy4, vp, busyp;
    logic [3:0] d1, d4, dp;
    logic [7:0] c1, c4, cp;

    int tests;
    int fails;

    cory_arb16 #(.BURST(1), .PARK(0)) u_b1 (
        .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_req(i_req),
`ifdef CORY_ARB16_PRIO_EN
        .i_prio(i_prio),
`endif
        .o_s_v(v1), .o_s_d(d1), .i_s_r(i_s_r), .o_busy(busy1), .o_cnt(c1)
    );

    cory_arb16 #(.BURST(4), .PARK(0)) u_b4 (
        .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_req(i_req),
`ifdef CORY_ARB16_PRIO_EN
        .i_prio(i_prio),
`endif
        .o_s_v(v4), .o_s_d(d4), .i_s_r(i_s_r), .o_busy(busy4), .o_cnt(c4)
    );

    cory_arb16 #(.BURST(4), .PARK(1)) u_pk (
        .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_req(i_req),
`ifdef CORY_ARB16_PRIO_EN
        .i_prio(i_prio),
`endif
        .o_s_v(vp), .o_s_d(dp), .i_s_r(i_s_r), .o_busy(busyp), .o_cnt(cp)
    );

`ifdef CORY_ARB16_PRIO_EN
    logic       v2, busy2;
    logic [3:0] d2;
    logic [7:0] c2;
    cory_arb16 #(.BURST(2), .PARK(0)) u_p2 (
        .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_req(i_req), .i_prio(i_prio),
        .o_s_v(v2), .o_s_d(d2), .i_s_r(i_s_r), .o_busy(busy2), .o_cnt(c2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req = 16'h0000;
        i_s_r = 1'b0;
        i_en  = 1'b1;
`ifdef CORY_ARB16_PRIO_EN
        i_prio = 16'h0000;
`endif
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_v", {31'd0, v4}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int exp_tok[$];
    int exp_cnt[$];

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b1;
        i_en    = 1'b1;
        i_req   = 16'h0000;
        i_s_r   = 1'b0;
`ifdef CORY_ARB16_PRIO_EN
        i_prio  = 16'h0000;
`endif
        #3;
        reset_n = 1'b0;
        #1;
        check("t1_rst_v", {31'd0, v4}, 32'd0);
        check("t1_rst_d", {28'd0, d4}, 32'd0);
        check("t1_rst_cnt", {24'd0, c4}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Test 1: no requests for 20 cycles -> nothing offered.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_v", {31'd0, v4}, 32'd0);
            check("t1_d", {28'd0, d4}, 32'd0);
            check("t1_cnt", {24'd0, c4}, 32'd0);
            check("t1_busy", {31'd0, busy4}, 32'd0);
        end

        // Test 2: BURST=1 alternates 0,15 with one-cycle first latency.
        do_reset();
        @(posedge clk);
        #1;
        i_req = 16'h8001;
        i_s_r = 1'b1;
        check("t2_pre_v", {31'd0, v1}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_v", {31'd0, v1}, 32'd1);
            check("t2_d", {28'd0, d1}, (i % 2 == 0) ? 32'd0 : 32'd15);
            check("t2_cnt", {24'd0, c1}, 32'd0);
        end

        // Test 3: BURST=4 runs of four between requesters 2 and 5.
        do_reset();
        exp_tok = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2};
        exp_cnt = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        @(posedge clk);
        #1;
        i_req = 16'h0024;
        i_s_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_v", {31'd0, v4}, 32'd1);
            check("t3_d", {28'd0, d4}, 32'(exp_tok[i]));
            check("t3_cnt", {24'd0, c4}, 32'(exp_cnt[i]));
        end

        // Test 4: stalled offer of 3 stays stable after its request drops.
        do_reset();
        @(posedge clk);
        #1;
        i_req = 16'h0008;
        i_s_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) i_req = 16'h0000;
            check("t4_v", {31'd0, v4}, 32'd1);
            check("t4_d", {28'd0, d4}, 32'd3);
            check("t4_busy", {31'd0, busy4}, 32'd1);
        end
        i_s_r = 1'b1;
        tick();
        check("t4_idle_v", {31'd0, v4}, 32'd0);
        check("t4_idle_d", {28'd0, d4}, 32'd0);
        check("t4_park_d", {28'd0, dp}, 32'd3);
        check("t4_park_v", {31'd0, vp}, 32'd0);
        i_req = 16'h0009;
        tick();
        check("t4_rot_v", {31'd0, v4}, 32'd1);
        check("t4_rot_d", {28'd0, d4}, 32'd0);

        // Test 5: i_en drop during offer of 7; resumes at 8.
        do_reset();
        @(posedge clk);
        #1;
        i_req = 16'h0080;
        i_s_r = 1'b0;
        tick();
        check("t5_offer_d", {28'd0, d4}, 32'd7);
        i_en = 1'b0;
        tick();
        check("t5_hold_v", {31'd0, v4}, 32'd1);
        check("t5_hold_d", {28'd0, d4}, 32'd7);
        i_s_r = 1'b1;
        tick();
        check("t5_idle_v", {31'd0, v4}, 32'd0);
        i_req = 16'hFFFF;
        tick();
        check("t5_dis_v", {31'd0, v4}, 32'd0);
        i_en = 1'b1;
        tick();
        check("t5_res_v", {31'd0, v4}, 32'd1);
        check("t5_res_d", {28'd0, d4}, 32'd8);
        check("t5_res_b1", {28'd0, d1}, 32'd8);

        // Test 7: asynchronous reset during a stalled offer clears it at once.
        do_reset();
        @(posedge clk);
        #1;
        i_req = 16'h0008;
        i_s_r = 1'b0;
        tick();
        tick();
        check("t7_pre_d", {28'd0, d4}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_v", {31'd0, v4}, 32'd0);
        check("t7_d", {28'd0, d4}, 32'd0);
        check("t7_park_d", {28'd0, dp}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        i_req = 16'hFFFF;
        tick();
        check("t7_ptr_d", {28'd0, d4}, 32'd0);

`ifdef CORY_ARB16_PRIO_EN
        // Test 6: priority requester 8 monopolises until its flag drops.
        do_reset();
        @(posedge clk);
        #1;
        i_req  = 16'hFFFF;
        i_prio = 16'h0100;
        i_s_r  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_d", {28'd0, d2}, 32'd8);
            check("t6_cnt", {24'd0, c2}, 32'(i % 2));
        end
        i_prio = 16'h0000;
        tick();
        check("t6_rr0", {28'd0, d2}, 32'd9);
        tick();
        check("t6_rr1", {28'd0, d2}, 32'd9);
        tick();
        check("t6_rr2", {28'd0, d2}, 32'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
